// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and ALUControl codes for the iterative mul/div unit.
package muldiv_pkg;
   typedef enum logic [1:0] {OP_UMUL = 2'b00, OP_SMUL = 2'b01, OP_UDIV = 2'b10} op_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] ALU_UMUL = 4'b1000;
   localparam logic [3:0] ALU_SMUL = 4'b1001;
   localparam logic [3:0] ALU_DIV  = 4'b1010;
   function automatic op_t decode_op(input logic [1:0] op);
      return (op == 2'b11) ? OP_UMUL : op_t'(op);
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (mul) or restoring shift-subtract (div) iteration.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH:0] w_sum, w_rem, w_diff;
   always_comb begin
      w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_d} : '0);
      w_rem  = {i_hi, i_lo[WIDTH-1]};
      w_diff = w_rem - {1'b0, i_d};
      // on borrow the shifted remainder is below the divisor, so its top bit is zero
      o_hi   = i_div ? (w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
      o_lo   = i_div ? {i_lo[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], i_lo[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: start/busy/done sequencer running WIDTH mul or div steps, with SMUL sign fix-up
// and a short-circuit for divide-by-zero.
module muldiv_seq import muldiv_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);
   state_t           r_state, w_next;
   op_t              r_op, w_op;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo, r_d, w_hi, w_lo, w_mag_a, w_mag_b;
   logic             r_neg, r_dz, w_accept, w_last, w_dz, w_div;
   logic [2*WIDTH-1:0] w_prod;
   assign w_op      = decode_op(op);
   assign w_div     = r_op == OP_UDIV;
   assign w_accept  = start && r_state != RUN;
   assign w_last    = r_cnt == CW'(WIDTH - 1);
   assign w_dz      = w_div && r_d == '0;
   assign w_mag_a   = (w_op == OP_SMUL && a[WIDTH-1]) ? -a : a;
   assign w_mag_b   = (w_op == OP_SMUL && b[WIDTH-1]) ? -b : b;
   assign w_prod    = (r_neg && w_last) ? -{w_hi, w_lo} : {w_hi, w_lo};
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign div_zero  = r_dz;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div(w_div), .i_hi(r_hi), .i_lo(r_lo), .i_d(r_d), .o_hi(w_hi), .o_lo(w_lo)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      busy   = r_state == RUN;
      done   = r_state == DONE;
      if (r_state == RUN) w_next = (w_last || w_dz) ? DONE : RUN;
      else w_next = w_accept ? RUN : IDLE;
   end
   // mul: lo holds the multiplier, d the multiplicand; div: lo holds the dividend, d the divisor
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op  <= OP_UMUL;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_d   <= '0;
         r_neg <= 1'b0;
         r_dz  <= 1'b0;
      end else if (w_accept) begin
         r_op  <= w_op;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= (w_op == OP_UDIV) ? a : w_mag_b;
         r_d   <= (w_op == OP_UDIV) ? b : w_mag_a;
         r_neg <= w_op == OP_SMUL && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_dz  <= 1'b0;
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_dz) begin
            r_lo <= '1;
            r_hi <= r_lo;
            r_dz <= 1'b1;
         end else begin
            {r_hi, r_lo} <= w_prod;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with a queue scoreboard checked whenever done is presented.
module tb_muldiv_seq;
   logic        clk = 0, reset = 0, start = 0;
   logic [1:0]  op = 0;
   logic [31:0] a = 0, b = 0;
   logic        busy, done, div_zero;
   logic [31:0] result_lo, result_hi;
   int          cyc = 0, total = 0, bad = 0;
   typedef struct {logic [31:0] lo; logic [31:0] hi; logic dz; int at;} exp_t;
   exp_t        sb[$];
   exp_t        m_e;
   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'(done), 64'd0);
         end else begin
            m_e = sb.pop_front();
            check("result_lo", 64'(result_lo), 64'(m_e.lo));
            check("result_hi", 64'(result_hi), 64'(m_e.hi));
            check("div_zero", 64'(div_zero), 64'(m_e.dz));
            check("done_cycle", 64'(cyc), 64'(m_e.at));
         end
      end
   end
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                        input int lat, input bit push);
      start = 1; op = o; a = x; b = y;
      @(posedge clk); #1;
      if (push) sb.push_back('{elo, ehi, edz, cyc + lat});
      start = 0;
      check("busy_after_accept", 64'(busy), 64'd1);
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
      @(negedge clk);
   endtask
   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (done) break;
      end
      check("wait_done", 64'(done), 64'd1);
   endtask
   initial begin
      #1 reset = 1;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_lo", 64'(result_lo), 64'd0);
      check("rst_hi", 64'(result_hi), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 0;
      @(negedge clk);
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32, 1); wait_idle();
      issue(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 32, 1); wait_idle();
      issue(2'b01, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b0, 32, 1); wait_idle();
      issue(2'b01, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 32, 1); wait_idle();
      issue(2'b11, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 32, 1); wait_idle();
      issue(2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1); wait_idle();
      issue(2'b10, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32, 1); wait_idle();
      issue(2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 1); wait_idle();
      issue(2'b10, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 32, 1);
      repeat (9) @(negedge clk);
      check("busy_mid_run", 64'(busy), 64'd1);
      start = 1; op = 2'b00; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 0;
      wait_idle();
      repeat (3) @(negedge clk);
      issue(2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 32, 1);
      wait_done();
      issue(2'b00, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 1'b0, 32, 1);
      wait_idle();
      issue(2'b10, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 32, 0);
      repeat (14) @(negedge clk);
      #2 reset = 1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_lo", 64'(result_lo), 64'd0);
      check("abort_hi", 64'(result_hi), 64'd0);
      check("abort_dz", 64'(div_zero), 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 0;
      repeat (40) @(negedge clk);
      issue(2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 32, 1);
      wait_idle();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
